// File: rtl/mr1_stim_pkg.sv
// Shared types and constants for the MR1 directed-stimulus responder.
// Holds the FSM state encoding, response FIFO entry and byte-lane helpers.
package mr1_stim_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE, TIMEOUT} state_t;

  localparam logic [31:0] NOP_INSN  = 32'h0000_0013;
  localparam logic [15:0] LFSR_SEED = 16'hACE1;

  localparam logic [1:0] SIZE_B = 2'd0;
  localparam logic [1:0] SIZE_H = 2'd1;
  localparam logic [1:0] SIZE_W = 2'd2;

  // age counts cycles since accept, saturating at the response latency
  typedef struct packed {
    logic [31:0] data;
    logic [2:0]  age;
  } rsp_entry_t;

  function automatic logic [3:0] size_be(input logic [1:0] size, input logic [1:0] off);
    case (size)
      SIZE_B:  return 4'b0001 << off;
      SIZE_H:  return off[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/mr1_stim_rsp_pipe.sv
// Fixed-latency in-order response FIFO: an entry pushed at accept becomes
// visible exactly LAT cycles later and pops in the cycle it is presented.
module mr1_stim_rsp_pipe
  import mr1_stim_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int LAT   = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        push,
  input  logic [31:0] push_data,
  output logic        can_push,
  output logic        rsp_valid,
  output logic [31:0] rsp_data
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [2:0] LAT_A = 3'(LAT);

  rsp_entry_t    slot_q [DEPTH];
  rsp_entry_t    slot_d [DEPTH];
  logic [PW-1:0] head_q, head_d, tail_q, tail_d;
  logic [CW-1:0] cnt_q, cnt_d;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign rsp_valid = (cnt_q != '0) && (slot_q[head_q].age >= LAT_A);
  assign rsp_data  = rsp_valid ? slot_q[head_q].data : 32'h0;
  // a full FIFO still accepts when its head leaves in the same cycle
  assign can_push  = (cnt_q < CW'(DEPTH)) || rsp_valid;

  always_comb begin
    slot_d = slot_q;
    head_d = head_q;
    tail_d = tail_q;
    for (int i = 0; i < DEPTH; i++) begin
      if (slot_q[i].age < LAT_A) slot_d[i].age = slot_q[i].age + 3'd1;
    end
    if (push) begin
      slot_d[tail_q] = '{data: push_data, age: 3'd1};
      tail_d = ptr_inc(tail_q);
    end
    if (rsp_valid) head_d = ptr_inc(head_q);
    cnt_d = cnt_q + CW'(push) - CW'(rsp_valid);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      cnt_q  <= cnt_d;
    end
  end

  always_ff @(posedge clk) slot_q <= slot_d;

endmodule

// File: rtl/mr1_directed_stim.sv
// Directed-stimulus responder for MR1 benches: program-table fetches, word RAM
// data, RVFI retire counters, done/timeout. MR1_STIM_BACKPRESSURE_EN adds LFSR ready gating.
module mr1_directed_stim
  import mr1_stim_pkg::*;
#(
  parameter int          PROG_DEPTH   = 16,
  parameter int          DMEM_DEPTH   = 8,
  parameter int          RSP_LAT      = 1,
  parameter int          MAX_OUTST    = 2,
  parameter logic [31:0] RESET_PC     = 32'h0,
  parameter int          TARGET_INSNS = 4,
  parameter int          TIMEOUT_CYC  = 20
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          prog_we,
  input  logic [$clog2(PROG_DEPTH)-1:0] prog_addr,
  input  logic [31:0]                   prog_data,
  input  logic                          start,
  input  logic                          instr_req_valid,
  output logic                          instr_req_ready,
  input  logic [31:0]                   instr_req_addr,
  output logic                          instr_rsp_valid,
  output logic [31:0]                   instr_rsp_data,
  input  logic                          data_req_valid,
  output logic                          data_req_ready,
  input  logic                          data_req_wr,
  input  logic [1:0]                    data_req_size,
  input  logic [31:0]                   data_req_addr,
  input  logic [31:0]                   data_req_data,
  output logic                          data_rsp_valid,
  output logic [31:0]                   data_rsp_data,
  input  logic                          rvfi_valid,
  input  logic [31:0]                   rvfi_insn,
  input  logic [3:0]                    rvfi_mem_rmask,
  input  logic [3:0]                    rvfi_mem_wmask,
  output logic [15:0]                   cnt_insn,
  output logic [15:0]                   cnt_ld,
  output logic [15:0]                   cnt_st,
  output logic                          done,
  output logic                          timeout,
  output state_t                        dbg_state
);

  localparam int PAW = $clog2(PROG_DEPTH);
  localparam int DAW = $clog2(DMEM_DEPTH);

  state_t         state_q, state_d;
  logic [15:0]    cnt_insn_q, cnt_insn_d, cnt_ld_q, cnt_ld_d, cnt_st_q, cnt_st_d;
  logic [31:0]    cyc_q, cyc_d;
  logic [31:0]    prog_q [PROG_DEPTH];
  logic [31:0]    prog_d [PROG_DEPTH];
  logic [31:0]    dmem_q [DMEM_DEPTH];
  logic [31:0]    dmem_d [DMEM_DEPTH];
  logic           in_run, bp_ok, i_can_push, d_can_push, i_push, d_push, d_store;
  logic [31:0]    fetch_off, fetch_word;
  logic [DAW-1:0] d_idx;
  logic [3:0]     d_be;
  logic           unused_bits;

`ifdef MR1_STIM_BACKPRESSURE_EN
  logic [15:0] lfsr_q, lfsr_d;
  assign lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
  always_ff @(posedge clk) begin
    if (!reset) lfsr_q <= LFSR_SEED;
    else        lfsr_q <= lfsr_d;
  end
  assign bp_ok = lfsr_q[0];
`else
  assign bp_ok = 1'b1;
`endif

  // Handshake: a request transfers on a cycle where valid && ready; responses
  // have no ready and are presented for exactly one cycle, in accept order.
  assign in_run          = (state_q == RUN);
  assign instr_req_ready = in_run && i_can_push && bp_ok;
  assign data_req_ready  = in_run && d_can_push && bp_ok;
  assign i_push          = instr_req_valid && instr_req_ready;
  assign d_push          = data_req_valid && data_req_ready && !data_req_wr;
  assign d_store         = data_req_valid && data_req_ready && data_req_wr;
  assign d_idx           = data_req_addr[DAW+1:2];
  assign d_be            = size_be(data_req_size, data_req_addr[1:0]);

  always_comb begin
    fetch_off  = instr_req_addr - RESET_PC;
    fetch_word = NOP_INSN;
    if (instr_req_addr[1:0] == 2'b00 && fetch_off[31:2] < 30'(PROG_DEPTH))
      fetch_word = prog_q[fetch_off[PAW+1:2]];
  end

  always_comb begin
    prog_d = prog_q;
    dmem_d = dmem_q;
    if (prog_we && state_q == IDLE) prog_d[prog_addr] = prog_data;
    if (d_store) begin
      for (int b = 0; b < 4; b++) begin
        if (d_be[b]) dmem_d[d_idx][8*b +: 8] = data_req_data[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    prog_q <= prog_d;
    dmem_q <= dmem_d;
  end

  always_comb begin
    state_d    = state_q;
    cnt_insn_d = cnt_insn_q;
    cnt_ld_d   = cnt_ld_q;
    cnt_st_d   = cnt_st_q;
    cyc_d      = cyc_q;
    if (in_run) begin
      cyc_d = cyc_q + 32'd1;
      if (rvfi_valid) begin
        if (rvfi_insn[1:0] == 2'b11) cnt_insn_d = sat_inc16(cnt_insn_q);
        if (rvfi_mem_rmask != 4'h0)  cnt_ld_d   = sat_inc16(cnt_ld_q);
        if (rvfi_mem_wmask != 4'h0)  cnt_st_d   = sat_inc16(cnt_st_q);
      end
    end
    case (state_q)
      IDLE: if (start) state_d = RUN;
      // done is checked first so it wins a same-cycle tie with timeout
      RUN: begin
        if (cnt_insn_d == 16'(TARGET_INSNS))  state_d = DONE;
        else if (cyc_d == 32'(TIMEOUT_CYC))   state_d = TIMEOUT;
      end
      default: state_d = state_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= IDLE;
      cnt_insn_q <= '0;
      cnt_ld_q   <= '0;
      cnt_st_q   <= '0;
      cyc_q      <= '0;
    end else begin
      state_q    <= state_d;
      cnt_insn_q <= cnt_insn_d;
      cnt_ld_q   <= cnt_ld_d;
      cnt_st_q   <= cnt_st_d;
      cyc_q      <= cyc_d;
    end
  end

  mr1_stim_rsp_pipe #(.DEPTH(MAX_OUTST), .LAT(RSP_LAT)) u_instr_pipe (
    .clk       (clk),
    .reset     (reset),
    .push      (i_push),
    .push_data (fetch_word),
    .can_push  (i_can_push),
    .rsp_valid (instr_rsp_valid),
    .rsp_data  (instr_rsp_data)
  );

  mr1_stim_rsp_pipe #(.DEPTH(MAX_OUTST), .LAT(RSP_LAT)) u_data_pipe (
    .clk       (clk),
    .reset     (reset),
    .push      (d_push),
    .push_data (dmem_q[d_idx]),
    .can_push  (d_can_push),
    .rsp_valid (data_rsp_valid),
    .rsp_data  (data_rsp_data)
  );

  assign cnt_insn    = cnt_insn_q;
  assign cnt_ld      = cnt_ld_q;
  assign cnt_st      = cnt_st_q;
  assign done        = (state_q == DONE);
  assign timeout     = (state_q == TIMEOUT);
  assign dbg_state   = state_q;
  assign unused_bits = ^{data_req_addr[31:DAW+2], rvfi_insn[31:2], fetch_off[1:0]};

endmodule

// File: tb/tb_mr1_directed_stim.sv
// Directed bench for mr1_directed_stim: three instances with different latency,
// depth and timeout share one stimulus bus; each scenario watches one instance.
module tb_mr1_directed_stim;
  import mr1_stim_pkg::*;

  logic        clk = 1'b0;
  logic        reset, prog_we, start, i_val, d_val, d_wr, rv_valid;
  logic [3:0]  prog_addr, rv_rmask, rv_wmask;
  logic [1:0]  d_size;
  logic [31:0] prog_data, i_addr, d_addr, d_wdata, rv_insn;

  logic        i_rdy [3], i_rv [3], d_rdy [3], d_rv [3], dn [3], to [3];
  logic [31:0] i_rd [3], d_rd [3];
  logic [15:0] c_ins [3], c_ld [3], c_st [3];
  state_t      st [3];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    mr1_directed_stim #(
      .PROG_DEPTH(16), .DMEM_DEPTH(8),
      .RSP_LAT(g == 0 ? 1 : (g == 1 ? 3 : 4)),
      .MAX_OUTST(g == 1 ? 3 : 2),
      .RESET_PC(32'h0), .TARGET_INSNS(2),
      .TIMEOUT_CYC(g == 0 ? 20 : 200)
    ) u_dut (
      .clk(clk), .reset(reset), .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
      .start(start), .instr_req_valid(i_val), .instr_req_ready(i_rdy[g]), .instr_req_addr(i_addr),
      .instr_rsp_valid(i_rv[g]), .instr_rsp_data(i_rd[g]), .data_req_valid(d_val),
      .data_req_ready(d_rdy[g]), .data_req_wr(d_wr), .data_req_size(d_size), .data_req_addr(d_addr),
      .data_req_data(d_wdata), .data_rsp_valid(d_rv[g]), .data_rsp_data(d_rd[g]),
      .rvfi_valid(rv_valid), .rvfi_insn(rv_insn), .rvfi_mem_rmask(rv_rmask), .rvfi_mem_wmask(rv_wmask),
      .cnt_insn(c_ins[g]), .cnt_ld(c_ld[g]), .cnt_st(c_st[g]), .done(dn[g]), .timeout(to[g]),
      .dbg_state(st[g])
    );
  end

  // ---- clock/reset and driver tasks ----
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    prog_we = 0; prog_addr = '0; prog_data = '0; start = 0;
    i_val = 0; i_addr = '0; d_val = 0; d_wr = 0; d_size = SIZE_W; d_addr = '0; d_wdata = '0;
    rv_valid = 0; rv_insn = '0; rv_rmask = '0; rv_wmask = '0;
  endtask

  task automatic do_reset();
    reset = 0;
    idle_inputs();
    tick();
    reset = 1;
  endtask

  task automatic load_word(input int k, input logic [31:0] w);
    prog_we = 1; prog_addr = 4'(k); prog_data = w;
    tick();
    prog_we = 0;
  endtask

  task automatic go();
    start = 1;
    tick();
    start = 0;
  endtask

  task automatic data_op(input logic wr, input logic [1:0] sz, input logic [31:0] a, input logic [31:0] w);
    d_val = 1; d_wr = wr; d_size = sz; d_addr = a; d_wdata = w;
    tick();
    d_val = 0; d_wr = 0;
  endtask

  task automatic fetch(input logic [31:0] a);
    i_val = 1; i_addr = a;
    tick();
    i_val = 0;
  endtask

  task automatic retire(input logic [31:0] insn, input logic [3:0] rm, input logic [3:0] wm);
    rv_valid = 1; rv_insn = insn; rv_rmask = rm; rv_wmask = wm;
    tick();
    rv_valid = 0; rv_rmask = '0; rv_wmask = '0;
  endtask

  // ---- scenarios ----
  task automatic test_reset();
    reset = 0;
    idle_inputs();
    tick();
    tick();
    for (int g = 0; g < 3; g++) begin
      total++; if (st[g] !== IDLE) begin bad++; $display("FAIL rst_state[%0d] got=%0d want=%0d", g, st[g], IDLE); end
      total++; if ({i_rdy[g], d_rdy[g], i_rv[g], d_rv[g], dn[g], to[g]} !== 6'b0) begin
        bad++; $display("FAIL rst_flags[%0d] got=%b want=000000", g, {i_rdy[g], d_rdy[g], i_rv[g], d_rv[g], dn[g], to[g]}); end
      total++; if ({c_ins[g], c_ld[g], c_st[g]} !== 48'h0) begin
        bad++; $display("FAIL rst_cnt[%0d] got=%h want=0", g, {c_ins[g], c_ld[g], c_st[g]}); end
    end
    reset = 1;
  endtask

  task automatic test_program_flow();
    do_reset();
    load_word(0, 32'h0000_2083);
    load_word(1, 32'h0210_80B3);
    go();
    total++; if (st[0] !== RUN) begin bad++; $display("FAIL t1_run got=%0d want=%0d", st[0], RUN); end
    d_val = 1; d_wr = 1; d_size = SIZE_W; d_addr = 32'h0; d_wdata = 32'h1;
    total++; if (d_rdy[0] !== 1'b1) begin bad++; $display("FAIL t1_st_ready got=%b want=1", d_rdy[0]); end
    tick();
    d_wr = 0; i_val = 1; i_addr = 32'h0;
    total++; if (d_rv[0] !== 1'b0) begin bad++; $display("FAIL t1_st_norsp got=%b want=0", d_rv[0]); end
    tick();
    d_val = 0; i_val = 0;
    total++; if (i_rv[0] !== 1'b1 || i_rd[0] !== 32'h0000_2083) begin
      bad++; $display("FAIL t1_fetch0 got=%b/%h want=1/00002083", i_rv[0], i_rd[0]); end
    total++; if (d_rv[0] !== 1'b1 || d_rd[0] !== 32'h1) begin
      bad++; $display("FAIL t1_load got=%b/%h want=1/00000001", d_rv[0], d_rd[0]); end
    fetch(32'h4);
    total++; if (i_rv[0] !== 1'b1 || i_rd[0] !== 32'h0210_80B3) begin
      bad++; $display("FAIL t1_fetch1 got=%b/%h want=1/021080b3", i_rv[0], i_rd[0]); end
    retire(32'h0000_2083, 4'hF, 4'h0);
    total++; if (i_rv[0] !== 1'b0) begin bad++; $display("FAIL t1_single_rsp got=%b want=0", i_rv[0]); end
    total++; if (c_ins[0] !== 16'd1 || c_ld[0] !== 16'd1 || dn[0] !== 1'b0) begin
      bad++; $display("FAIL t1_ret_lw got=%0d/%0d/%b want=1/1/0", c_ins[0], c_ld[0], dn[0]); end
    retire(32'h0000_C004, 4'h0, 4'hF);
    total++; if (c_ins[0] !== 16'd1 || c_st[0] !== 16'd1) begin
      bad++; $display("FAIL t1_ret_c got=%0d/%0d want=1/1", c_ins[0], c_st[0]); end
    retire(32'h0210_80B3, 4'h0, 4'h0);
    total++; if (c_ins[0] !== 16'd2 || dn[0] !== 1'b1 || st[0] !== DONE) begin
      bad++; $display("FAIL t1_done got=%0d/%b/%0d want=2/1/%0d", c_ins[0], dn[0], st[0], DONE); end
    retire(32'h0000_2083, 4'hF, 4'hF);
    total++; if (c_st[0] !== 16'd1 || dn[0] !== 1'b1 || i_rdy[0] !== 1'b0) begin
      bad++; $display("FAIL t1_after_done got=%0d/%b/%b want=1/1/0", c_st[0], dn[0], i_rdy[0]); end
  endtask

  task automatic test_stream(input int g, input int lat, input int maxo, input string tag);
    logic [31:0] exp_q[$];
    int          acc_q[$];
    int          sent, got;
    logic        exp_v, exp_r;
    sent = 0;
    got  = 0;
    do_reset();
    for (int k = 0; k < 6; k++) load_word(k, 32'hC0DE_0100 + 32'(k));
    go();
    for (int t = 0; t < 40; t++) begin
      exp_v = (acc_q.size() > 0) && (acc_q[0] + lat == t);
      total++; if (i_rv[g] !== exp_v) begin bad++; $display("FAIL %s_rsp_valid t=%0d got=%b want=%b", tag, t, i_rv[g], exp_v); end
      if (exp_v) begin
        if (i_rv[g] === 1'b1) begin
          got++;
          total++; if (i_rd[g] !== exp_q[0]) begin bad++; $display("FAIL %s_rsp_data t=%0d got=%h want=%h", tag, t, i_rd[g], exp_q[0]); end
        end
        void'(acc_q.pop_front());
        void'(exp_q.pop_front());
      end
      exp_r = (acc_q.size() < maxo);
      i_val = (sent < 6);
      i_addr = 32'(4 * sent);
      if (sent < 6) begin
        total++; if (i_rdy[g] !== exp_r) begin bad++; $display("FAIL %s_ready t=%0d got=%b want=%b", tag, t, i_rdy[g], exp_r); end
        if (i_rdy[g] === 1'b1) begin
          acc_q.push_back(t);
          exp_q.push_back(32'hC0DE_0100 + 32'(sent));
          sent++;
        end
      end
      tick();
    end
    i_val = 0;
    total++; if (sent != 6 || got != 6) begin bad++; $display("FAIL %s_count got=%0d/%0d want=6/6", tag, sent, got); end
  endtask

  task automatic test_byte_lanes();
    do_reset();
    go();
    data_op(1, SIZE_W, 32'h4, 32'h0);
    data_op(1, SIZE_B, 32'h5, 32'h0000_AB00);
    total++; if (d_rv[0] !== 1'b0) begin bad++; $display("FAIL t4_store_norsp got=%b want=0", d_rv[0]); end
    data_op(0, SIZE_W, 32'h4, 32'h0);
    total++; if (d_rv[0] !== 1'b1 || d_rd[0] !== 32'h0000_AB00) begin
      bad++; $display("FAIL t4_sb got=%b/%h want=1/0000ab00", d_rv[0], d_rd[0]); end
    data_op(1, SIZE_H, 32'h6, 32'hBEEF_0000);
    data_op(0, SIZE_W, 32'h24, 32'h0);
    total++; if (d_rv[0] !== 1'b1 || d_rd[0] !== 32'hBEEF_AB00) begin
      bad++; $display("FAIL t4_sh_alias got=%b/%h want=1/beefab00", d_rv[0], d_rd[0]); end
    data_op(1, SIZE_B, 32'h7, 32'h1200_0000);
    data_op(0, SIZE_W, 32'h4, 32'h0);
    total++; if (d_rd[0] !== 32'h12EF_AB00) begin bad++; $display("FAIL t4_sb_hi got=%h want=12efab00", d_rd[0]); end
  endtask

  task automatic test_fetch_bounds();
    do_reset();
    load_word(15, 32'h1234_5678);
    go();
    load_word(15, 32'hDEAD_BEEF);
    fetch(32'h40);
    total++; if (i_rv[0] !== 1'b1 || i_rd[0] !== 32'h0000_0013) begin
      bad++; $display("FAIL t5_past_end got=%b/%h want=1/00000013", i_rv[0], i_rd[0]); end
    fetch(32'h2);
    total++; if (i_rv[0] !== 1'b1 || i_rd[0] !== 32'h0000_0013) begin
      bad++; $display("FAIL t5_misaligned got=%b/%h want=1/00000013", i_rv[0], i_rd[0]); end
    fetch(32'h3C);
    total++; if (i_rv[0] !== 1'b1 || i_rd[0] !== 32'h1234_5678) begin
      bad++; $display("FAIL t5_last_word got=%b/%h want=1/12345678", i_rv[0], i_rd[0]); end
  endtask

  task automatic test_timeout();
    do_reset();
    go();
    repeat (19) tick();
    total++; if (to[0] !== 1'b0 || st[0] !== RUN) begin bad++; $display("FAIL t6_early got=%b/%0d want=0/%0d", to[0], st[0], RUN); end
    tick();
    total++; if (to[0] !== 1'b1 || i_rdy[0] !== 1'b0) begin bad++; $display("FAIL t6_timeout got=%b/%b want=1/0", to[0], i_rdy[0]); end
    tick();
    tick();
    total++; if (to[0] !== 1'b1 || st[0] !== TIMEOUT) begin bad++; $display("FAIL t6_sticky got=%b/%0d want=1/%0d", to[0], st[0], TIMEOUT); end
    do_reset();
    go();
    retire(32'h0000_0013, 4'h0, 4'h0);
    total++; if (c_ins[0] !== 16'd1) begin bad++; $display("FAIL t6_count got=%0d want=1", c_ins[0]); end
    i_val = 1; i_addr = 32'h0;
    tick();
    reset = 0;
    tick();
    total++; if (st[0] !== IDLE || i_rdy[0] !== 1'b0 || i_rv[0] !== 1'b0 || c_ins[0] !== 16'd0 || to[0] !== 1'b0) begin
      bad++; $display("FAIL t6_midrun_reset got=%0d/%b/%b/%0d/%b want=%0d/0/0/0/0", st[0], i_rdy[0], i_rv[0], c_ins[0], to[0], IDLE); end
    reset = 1;
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_program_flow();
    test_stream(1, 3, 3, "t2_back_to_back");
    test_stream(2, 4, 2, "t3_outstanding");
    test_byte_lanes();
    test_fetch_bounds();
    test_timeout();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
